// File: rtl/i2c_bus_scheduler_pkg.sv
// Shared types for the I2C bus scheduler:
// FSM encoding and the latched transaction descriptor.
package i2c_sched_pkg;

  localparam int ADDR_W = 7;
  localparam int REG_W  = 8;
  localparam int LEN_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_ABORT,
    S_FINISH,
    S_GAP
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] dev_addr;
    logic [REG_W-1:0]  reg_addr;
    logic [LEN_W-1:0]  len;
    logic              rd;
  } desc_t;

endpackage

// File: rtl/i2c_bus_scheduler_if.sv
// Requester and engine signals of the scheduler.
// slave = scheduler side, master = requesters plus engine.
interface i2c_bus_scheduler_if
  import i2c_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_dev_addr;
  logic [NUM_REQ*REG_W-1:0]  req_reg_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        req_rd;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic [NUM_REQ-1:0]        fault;
  logic [NUM_REQ-1:0]        fault_clr;
  logic                      eng_start;
  logic [ADDR_W-1:0]         eng_dev_addr;
  logic [REG_W-1:0]          eng_reg_addr;
  logic [LEN_W-1:0]          eng_len;
  logic                      eng_rd;
  logic                      eng_abort;
  logic                      eng_done;
  logic                      eng_nack;
  logic                      busy;

  modport master (
    output req, req_dev_addr, req_reg_addr,
    output req_len, req_rd, fault_clr,
    output eng_done, eng_nack,
    input  grant, done, err, fault,
    input  eng_start, eng_dev_addr, eng_reg_addr,
    input  eng_len, eng_rd, eng_abort, busy
  );

  modport slave (
    input  req, req_dev_addr, req_reg_addr,
    input  req_len, req_rd, fault_clr,
    input  eng_done, eng_nack,
    output grant, done, err, fault,
    output eng_start, eng_dev_addr, eng_reg_addr,
    output eng_len, eng_rd, eng_abort, busy
  );

endinterface

// File: rtl/i2c_bus_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first eligible
// index above ptr_i, wrapping around.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   elig_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [IDW-1:0] idx_o,
  output logic           vld_o
);

  int j;

  // Scan farthest-first so the nearest eligible index wins.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    j     = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (elig_i[j]) begin
        idx_o = IDW'(j);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_scheduler.sv
// Round-robin owner of a shared I2C engine with
// watchdog, bus-free gap and NACK quarantine.
module i2c_bus_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int GAP_CYCLES     = 50,
  parameter int MAX_NACK       = 3
) (
  input logic clk,
  input logic rst,
  i2c_bus_scheduler_if.slave bus
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = $clog2(TIMEOUT_CYCLES);
  localparam int NW  = $clog2(MAX_NACK + 1);
  localparam int GW  = (GAP_CYCLES > 1) ?
                       $clog2(GAP_CYCLES) : 1;

  localparam logic [TW-1:0] T_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [NW-1:0] N_MAX = NW'(MAX_NACK);
  localparam logic [NW-1:0] N_ONE = NW'(1);

  state_e             state_q;
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     id_q;
  desc_t              desc_q;
  logic [TW-1:0]      timer_q;
  logic [GW-1:0]      gap_q;
  logic               err_rec_q;
  logic [NW-1:0]      nack_q [NUM_REQ];
  logic [NUM_REQ-1:0] fault_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] err_q;
  logic               start_q;
  logic               abort_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] elig;
  logic [IDW-1:0]     arb_idx;
  logic               arb_vld;
  desc_t              pick;
  int                 base;

  assign elig = bus.req & ~fault_q;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_arb (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .idx_o  (arb_idx),
    .vld_o  (arb_vld)
  );

  always_comb begin
    base          = int'(arb_idx);
    pick.dev_addr =
      bus.req_dev_addr[base*ADDR_W +: ADDR_W];
    pick.reg_addr =
      bus.req_reg_addr[base*REG_W +: REG_W];
    pick.len      = bus.req_len[base*LEN_W +: LEN_W];
    pick.rd       = bus.req_rd[base];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= IDW'(NUM_REQ - 1);
      id_q      <= '0;
      desc_q    <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      err_rec_q <= 1'b0;
      fault_q   <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
        nack_q[i] <= '0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      done_q  <= '0;
      err_q   <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (arb_vld) begin
            id_q    <= arb_idx;
            ptr_q   <= arb_idx;
            desc_q  <= pick;
            grant_q <= NUM_REQ'(1) << arb_idx;
            busy_q  <= 1'b1;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (desc_q.len == '0) begin
            err_rec_q <= 1'b1;
            state_q   <= S_FINISH;
          end else begin
            start_q <= 1'b1;
            timer_q <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.eng_done) begin
            err_rec_q <= bus.eng_nack;
            state_q   <= S_FINISH;
          end else if (timer_q == T_LAST) begin
            abort_q <= 1'b1;
            state_q <= S_ABORT;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_ABORT: begin
          err_rec_q <= 1'b1;
          state_q   <= S_FINISH;
        end
        S_FINISH: begin
          done_q[id_q] <= 1'b1;
          err_q[id_q]  <= err_rec_q;
          if (err_rec_q) begin
            if (nack_q[id_q] != N_MAX)
              nack_q[id_q] <= nack_q[id_q] + N_ONE;
            if (nack_q[id_q] >= N_MAX - N_ONE)
              fault_q[id_q] <= 1'b1;
          end else begin
            nack_q[id_q] <= '0;
          end
          grant_q <= '0;
          gap_q   <= '0;
          if (GAP_CYCLES == 0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == G_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Placed last so a clear beats a same-cycle quarantine.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.fault_clr[i]) begin
          fault_q[i] <= 1'b0;
          nack_q[i]  <= '0;
        end
      end
    end
  end

  assign bus.grant        = grant_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.fault        = fault_q;
  assign bus.eng_start    = start_q;
  assign bus.eng_abort    = abort_q;
  assign bus.eng_dev_addr = desc_q.dev_addr;
  assign bus.eng_reg_addr = desc_q.reg_addr;
  assign bus.eng_len      = desc_q.len;
  assign bus.eng_rd       = desc_q.rd;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// Scoreboard bench for i2c_bus_scheduler with a
// behavioural engine model and directed scenarios.
module tb_i2c_bus_scheduler;
  import i2c_sched_pkg::*;

  localparam int N   = 4;
  localparam int TO  = 64;
  localparam int GAP = 5;
  localparam int MN  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_bus_scheduler_if #(.NUM_REQ(N)) bus ();

  i2c_bus_scheduler #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO),
    .GAP_CYCLES     (GAP),
    .MAX_NACK       (MN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  logic [N-1:0]   exp_grant [$];
  logic [18:0]    exp_start [$];
  logic [2*N-1:0] exp_done  [$];

  int   eng_mode = 0;
  int   eng_lat  = 20;
  logic eng_nk   = 1'b0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s act=missing exp=event", nm);
  endtask

  function automatic logic [18:0] dsc(
    logic [6:0] d, logic [7:0] r,
    logic [2:0] l, logic rd);
    return {d, r, l, rd};
  endfunction

  task automatic set_desc(int i, logic [6:0] d,
                          logic [7:0] r,
                          logic [2:0] l, logic rd);
    bus.req_dev_addr[7*i +: 7] = d;
    bus.req_reg_addr[8*i +: 8] = r;
    bus.req_len[3*i +: 3]      = l;
    bus.req_rd[i]              = rd;
  endtask

  function automatic bit ev(int w);
    case (w)
      0:       return bus.grant != '0;
      1:       return bus.done != '0;
      2:       return bus.eng_start;
      default: return bus.eng_abort;
    endcase
  endfunction

  task automatic wait_ev(string nm, int w, int maxc,
                         output int at);
    at = -1;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (ev(w)) begin
        at = cyc;
        return;
      end
    end
    fail(nm);
  endtask

  // Engine model: eng_done eng_lat cycles after eng_start.
  initial begin
    bus.eng_done = 1'b0;
    bus.eng_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.eng_start === 1'b1 && eng_mode == 0) begin
        repeat (eng_lat - 1) @(negedge clk);
        bus.eng_done = 1'b1;
        bus.eng_nack = eng_nk;
        @(negedge clk);
        bus.eng_done = 1'b0;
        bus.eng_nack = 1'b0;
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents output.
  initial begin
    logic [N-1:0] pg;
    pg = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.grant != '0 && pg == '0) begin
          if (exp_grant.size() == 0)
            chk("unexp_grant", 32'(bus.grant), 0);
          else
            chk("grant", 32'(bus.grant),
                32'(exp_grant.pop_front()));
        end
        if (bus.eng_start) begin
          if (exp_start.size() == 0)
            chk("unexp_start", 1, 0);
          else
            chk("start_desc",
                32'({bus.eng_dev_addr, bus.eng_reg_addr,
                     bus.eng_len, bus.eng_rd}),
                32'(exp_start.pop_front()));
        end
        if (bus.done != '0) begin
          if (exp_done.size() == 0)
            chk("unexp_done", 32'(bus.done), 0);
          else
            chk("done_err", 32'({bus.done, bus.err}),
                32'(exp_done.pop_front()));
        end
      end
      pg = bus.grant;
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int g, d, s, a, n;
    logic [6:0] da;
    logic [7:0] ra;
    bus.req          = '0;
    bus.req_dev_addr = '0;
    bus.req_reg_addr = '0;
    bus.req_len      = '0;
    bus.req_rd       = '0;
    bus.fault_clr    = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", 32'({bus.grant, bus.done, bus.err,
        bus.fault, bus.busy, bus.eng_start,
        bus.eng_abort}), 0);
    chk("rst_desc", 32'({bus.eng_dev_addr,
        bus.eng_reg_addr, bus.eng_len, bus.eng_rd}), 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: single read, 20-cycle engine
    set_desc(0, 7'h1E, 8'h03, 3'd6, 1'b1);
    exp_grant.push_back(4'b0001);
    exp_start.push_back(dsc(7'h1E, 8'h03, 3'd6, 1'b1));
    exp_done.push_back({4'b0001, 4'b0000});
    bus.req = 4'b0001;
    chk("t1_grant_pre", 32'(bus.grant), 0);
    @(negedge clk);
    chk("t1_grant_lat", 32'(bus.grant), 32'b0001);
    bus.req = '0;
    @(negedge clk);
    chk("t1_start_lat", 32'(bus.eng_start), 1);
    wait_ev("t1_done", 1, 100, d);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("t1_busy_gap", n, GAP);

    // 2: all four requesting, round-robin order
    do_reset();
    eng_lat = 3;
    for (int i = 0; i < N; i++) begin
      da = 7'(8'h10 + i);
      ra = 8'(8'h20 + i);
      set_desc(i, da, ra, 3'(i + 1), i[0]);
    end
    for (int k = 0; k < 8; k++) begin
      da = 7'(8'h10 + k % 4);
      ra = 8'(8'h20 + k % 4);
      exp_grant.push_back(4'(1 << (k % 4)));
      exp_start.push_back(dsc(da, ra, 3'(k % 4 + 1),
                              k[0]));
      exp_done.push_back({4'(1 << (k % 4)), 4'b0000});
    end
    bus.req = 4'b1111;
    d = -1000;
    for (int k = 0; k < 8; k++) begin
      wait_ev("t2_grant", 0, 200, g);
      if (k > 0)
        chk("t2_gap_ok", 32'(g - d > GAP), 1);
      if (k == 7) bus.req = '0;
      wait_ev("t2_done", 1, 200, d);
    end

    // 3: watchdog abort, then next requester
    eng_mode = 1;
    exp_grant.push_back(4'b0001);
    exp_start.push_back(dsc(7'h10, 8'h20, 3'd1, 1'b0));
    exp_done.push_back({4'b0001, 4'b0001});
    exp_grant.push_back(4'b0010);
    exp_start.push_back(dsc(7'h11, 8'h21, 3'd2, 1'b1));
    exp_done.push_back({4'b0010, 4'b0000});
    bus.req = 4'b0011;
    wait_ev("t3_grant0", 0, 50, g);
    bus.req = 4'b0010;
    wait_ev("t3_start", 2, 10, s);
    wait_ev("t3_abort", 3, TO + 10, a);
    chk("t3_abort_lat", a - s, TO);
    eng_mode = 0;
    wait_ev("t3_done0", 1, 10, d);
    wait_ev("t3_grant1", 0, 50, g);
    bus.req = '0;
    wait_ev("t3_done1", 1, 50, d);

    // 4: three NACKs quarantine requester 2
    eng_nk = 1'b1;
    set_desc(2, 7'h12, 8'h22, 3'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      exp_grant.push_back(4'b0100);
      exp_start.push_back(dsc(7'h12, 8'h22, 3'd3, 1'b0));
      exp_done.push_back({4'b0100, 4'b0100});
    end
    bus.req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      wait_ev("t4_grant", 0, 50, g);
      wait_ev("t4_done", 1, 50, d);
      chk("t4_fault", 32'(bus.fault[2]), 32'(k == 2));
    end
    repeat (30) @(negedge clk);
    chk("t4_no_grant", 32'(bus.grant), 0);
    eng_nk = 1'b0;
    exp_grant.push_back(4'b0100);
    exp_start.push_back(dsc(7'h12, 8'h22, 3'd3, 1'b0));
    exp_done.push_back({4'b0100, 4'b0000});
    bus.fault_clr = 4'b0100;
    @(negedge clk);
    bus.fault_clr = '0;
    chk("t4_fault_clr", 32'(bus.fault[2]), 0);
    wait_ev("t4_regrant", 0, 20, g);
    bus.req = '0;
    wait_ev("t4_done_ok", 1, 50, d);

    // 5: zero length skips the engine
    set_desc(1, 7'h11, 8'h21, 3'd0, 1'b1);
    exp_grant.push_back(4'b0010);
    exp_done.push_back({4'b0010, 4'b0010});
    bus.req = 4'b0010;
    wait_ev("t5_grant", 0, 50, g);
    bus.req = '0;
    wait_ev("t5_done", 1, 20, d);
    chk("t5_done_lat", d - g, 2);

    // 6: async reset during RUN
    eng_mode = 1;
    exp_grant.push_back(4'b0001);
    exp_start.push_back(dsc(7'h10, 8'h20, 3'd1, 1'b0));
    bus.req = 4'b0001;
    wait_ev("t6_grant", 0, 50, g);
    bus.req = '0;
    wait_ev("t6_start", 2, 10, s);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_rst_outs", 32'({bus.grant, bus.done, bus.err,
        bus.fault, bus.busy, bus.eng_start,
        bus.eng_abort}), 0);
    chk("t6_rst_desc", 32'({bus.eng_dev_addr,
        bus.eng_reg_addr, bus.eng_len, bus.eng_rd}), 0);
    set_desc(1, 7'h11, 8'h21, 3'd2, 1'b1);
    bus.req  = 4'b0110;
    eng_mode = 0;
    exp_grant.push_back(4'b0010);
    exp_start.push_back(dsc(7'h11, 8'h21, 3'd2, 1'b1));
    exp_done.push_back({4'b0010, 4'b0000});
    @(negedge clk);
    rst = 1'b1;
    wait_ev("t6_grant1", 0, 20, g);
    bus.req = '0;
    wait_ev("t6_done1", 1, 50, d);

    repeat (GAP + 5) @(negedge clk);
    chk("sb_empty", exp_grant.size() + exp_start.size()
        + exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
